demux1to4_32bit_buf: RTL and testbench
======================================

// Module: demux1to4_32bit_buf
// PURPOSE
// - Buffered 1-to-4 demultiplexer: routes one 32-bit input stream to one of four output channels selected per word by in_sel.
// - Counterpart of the datapath 4:1 selector. Fans a producer (e.g. store/writeback path) out to four independent consumers (data memory, I/O ports).
// - Each channel has its own small FIFO, so one stalled consumer blocks only words addressed to it.
// PARAMETERS
// - WIDTH       32   data width of input and each output channel
// - FIFO_DEPTH  2    entries per channel FIFO; power of two, >= 2
// - CNT_W       16   width of per-channel statistics counters (DEMUX_STATS_EN only)
// PORTS
// - clk        in   1          rising-edge clock
// - reset      in   1          asynchronous, active-high reset
// - in_data    in   WIDTH      input word
// - in_sel     in   2          destination channel of in_data (0..3)
// - in_valid   in   1          in_data/in_sel valid
// - in_ready   out  1          block accepts word this cycle
// - out_data   out  4*WIDTH    channel k data at [k*WIDTH +: WIDTH]
// - out_valid  out  4          channel k holds a word
// - out_ready  in   4          consumer k takes the word this cycle
// - stat_count out  4*CNT_W    words delivered per channel; present only with DEMUX_STATS_EN
// BEHAVIOUR
// - Reset (async assert, sync release): all FIFOs empty; out_valid=0, out_data=0, in_ready=1, stat_count=0.
// - in_ready = !full[in_sel]. Combinational from in_sel and FIFO state only, never from out_ready.
// - Accept: in_valid && in_ready at rising edge -> word pushed into FIFO[in_sel].
// - Deliver: out_valid[k] && out_ready[k] at edge -> head of FIFO[k] popped.
// - Latency: word accepted at edge N is visible on out_data/out_valid after edge N (one cycle). No combinational in->out path.
// - out_data[k] = FIFO[k] head while out_valid[k]=1; holds its last value while empty (no X, no zeroing).
// - Per-channel states EMPTY (cnt=0), PARTIAL, FULL (cnt=FIFO_DEPTH); out_valid[k] = (state!=EMPTY).
// - Simultaneous push+pop on the same PARTIAL channel: both occur, count unchanged, order preserved.
// - FULL channel with pop in same cycle: in_ready stays 0 that cycle. No pass-through; push happens the next cycle.
// - Push to EMPTY: word visible next cycle, no bypass.
// - Pops on any set of channels in one cycle are independent. At most one push per cycle.
// - Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
// - Per-channel ordering strictly FIFO. No ordering guarantee across channels.
// - in_valid=0: in_sel and in_data are don't-care, no state change.
// - Reset mid-operation: all buffered words discarded immediately; out_valid drops asynchronously.
// CONFIGURATION
// - `DEMUX_STATS_EN defined: adds stat_count port. Counter k increments on each pop of channel k and saturates at 2**CNT_W-1. Reset to 0.
// - Not defined: no stat_count port, no counter logic. All other behaviour identical.
// STRUCTURE
// - Package demux_pkg: NUM_CH=4, typedef logic [1:0] ch_sel_t, typedef enum {CH_EMPTY, CH_PARTIAL, CH_FULL} ch_state_t.
// - Sub-module demux_chan_fifo (WIDTH, FIFO_DEPTH): push/pop, full/empty, head data. Instantiated 4x via generate.
// - Top level: in_sel one-hot push decode, in_ready mux, optional stats counters.
// TESTING
// - Reset: assert reset mid-traffic -> out_valid=4'b0000 at once, in_ready=1; after release the stats are 0.
// - Routing: push 32'hA0000000..32'hA0000003 with in_sel=0,1,2,3, out_ready=4'hF -> each appears on its own channel one cycle after accept.
// - Backpressure: out_ready[2]=0, push 3 words to ch2 (DEPTH=2) -> in_ready=0 on 3rd word; pushes to ch0 still accepted.
// - Full+pop: ch1 FULL, raise out_ready[1] -> in_ready for sel=1 is 0 that cycle, 1 next cycle; order 11,22,33 preserved.
// - Wrap: 10 words of value i (i=0..9) to ch3 with out_ready[3] toggling every cycle -> output sequence 0..9, no loss or duplicate.
// - Stats (`DEMUX_STATS_EN, CNT_W=4): 20 pops on ch0 -> stat_count[0] saturates at 15; other counters unchanged.

Source files
------------

// File: rtl/demux1to4_32bit_buf_pkg.sv
// Shared types for the buffered 1-to-4 demultiplexer: channel count, select type and
// per-channel occupancy states.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef logic [1:0] ch_sel_t;

    typedef enum logic [1:0] {
        CH_EMPTY,
        CH_PARTIAL,
        CH_FULL
    } ch_state_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
        logic [NUM_CH-1:0] w_oh;
        w_oh      = '0;
        w_oh[sel] = 1'b1;
        return w_oh;
    endfunction

endpackage

// File: rtl/demux1to4_32bit_buf_if.sv
// Bus bundle for demux1to4_32bit_buf: one input stream, four output channels and,
// when DEMUX_STATS_EN is defined, the per-channel delivery counters.
interface demux1to4_32bit_buf_if
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) ();

    logic [WIDTH-1:0]        in_data;
    ch_sel_t                 in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
`ifdef DEMUX_STATS_EN
    logic [NUM_CH*CNT_W-1:0] stat_count;
`endif

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
`ifdef DEMUX_STATS_EN
        ,
        input  stat_count
`endif
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
`ifdef DEMUX_STATS_EN
        ,
        output stat_count
`endif
    );

endinterface

// File: rtl/demux1to4_32bit_buf_chan_fifo.sv
// Single-channel FIFO for the demultiplexer. Head output shows the oldest entry while
// non-empty and keeps showing the last delivered word once drained.
module demux_chan_fifo
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned     PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  CNT_MAX = (PTR_W + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_last;

    ch_state_t        w_state;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W:0]   w_count_next;

    always_comb begin
        w_state = CH_PARTIAL;
        if (r_count == '0) begin
            w_state = CH_EMPTY;
        end else if (r_count == CNT_MAX) begin
            w_state = CH_FULL;
        end
    end

    assign w_push  = i_push && (w_state != CH_FULL);
    assign w_pop   = i_pop && (w_state != CH_EMPTY);
    assign o_full  = (w_state == CH_FULL);
    assign o_empty = (w_state == CH_EMPTY);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (PTR_W + 1)'(1);
            2'b01:   w_count_next = r_count - (PTR_W + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Once drained, the slot under r_rd_ptr is stale, so fall back to the last popped word.
    assign o_head = o_empty ? r_last : r_mem[r_rd_ptr];

endmodule

// File: rtl/demux1to4_32bit_buf.sv
// Buffered 1-to-4 demultiplexer with one FIFO per output channel.
// Define DEMUX_STATS_EN to add saturating per-channel delivery counters (stat_count).
module demux1to4_32bit_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 16
) (
    input logic                   clk,
    input logic                   reset,
    demux1to4_32bit_buf_if.slave  bus
);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [WIDTH-1:0]  w_head [NUM_CH];
    logic              w_in_ready;

    // Readiness looks only at the addressed FIFO, never at out_ready.
    always_comb begin
        w_in_ready = !w_full[bus.in_sel];
        w_push     = '0;
        if (bus.in_valid && w_in_ready) begin
            w_push = sel_onehot(bus.in_sel);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = ~w_empty;
    assign w_pop         = ~w_empty & bus.out_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        demux_chan_fifo #(
            .WIDTH      (WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[k]),
            .i_data  (bus.in_data),
            .i_pop   (w_pop[k]),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k]),
            .o_head  (w_head[k])
        );

        assign bus.out_data[k*WIDTH +: WIDTH] = w_head[k];
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] r_stat [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_stat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_pop[k] && (r_stat[k] != '1)) begin
                    r_stat[k] <= r_stat[k] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
        assign bus.stat_count[k*CNT_W +: CNT_W] = r_stat[k];
    end
`endif

endmodule

// File: tb/tb_demux1to4_32bit_buf.sv
// Directed bench for demux1to4_32bit_buf: routing, backpressure, full+pop, pointer wrap,
// async reset and (with DEMUX_STATS_EN) counter saturation.
module tb_demux1to4_32bit_buf;
    import demux_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tx;
    int   rx;

    always #5 clk = ~clk;

    demux1to4_32bit_buf_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    demux1to4_32bit_buf #(
        .WIDTH      (W),
        .FIFO_DEPTH (2),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int s, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_sel   = ch_sel_t'(s);
        bus.in_data  = d;
    endtask

    function automatic logic [31:0] data_of(input int k);
        return bus.out_data[k*W +: W];
    endfunction

`ifdef DEMUX_STATS_EN
    function automatic logic [31:0] stat_of(input int k);
        return 32'(bus.stat_count[k*CW +: CW]);
    endfunction
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.out_ready = 4'h0;
        drive(1'b0, 0, 32'h0);
        #1;
        check("reset_valid", 32'(bus.out_valid), 32'h0);
        check("reset_ready", 32'(bus.in_ready), 32'h1);
        for (int k = 0; k < 4; k++) check("reset_data", data_of(k), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Routing: one word per channel, consumers always ready.
        bus.out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("route_valid", 32'(bus.out_valid), 32'(1 << (k - 1)));
                check("route_data", data_of(k - 1), 32'hA000_0000 + 32'(k - 1));
            end
            drive(1'b1, k, 32'hA000_0000 + 32'(k));
            #1;
            check("route_ready", 32'(bus.in_ready), 32'h1);
        end
        @(negedge clk);
        check("route_valid", 32'(bus.out_valid), 32'h8);
        check("route_data", data_of(3), 32'hA000_0003);
        drive(1'b0, 0, 32'h0);
        @(negedge clk);
        check("route_drained", 32'(bus.out_valid), 32'h0);
        check("route_hold", data_of(3), 32'hA000_0003);

        // Backpressure on channel 2.
        bus.out_ready = 4'b1011;
        @(negedge clk);
        drive(1'b1, 2, 32'hB1);
        #1 check("bp_ready1", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        drive(1'b1, 2, 32'hB2);
        #1 check("bp_ready2", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        drive(1'b1, 2, 32'hB3);
        #1 check("bp_full", 32'(bus.in_ready), 32'h0);
        bus.in_sel  = 2'd0;
        bus.in_data = 32'hC0;
        #1 check("bp_ch0_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        drive(1'b0, 0, 32'h0);
        check("bp_valid", 32'(bus.out_valid), 32'h5);
        check("bp_ch0_data", data_of(0), 32'hC0);
        check("bp_ch2_head", data_of(2), 32'hB1);
        bus.out_ready = 4'hF;
        @(negedge clk);
        check("bp_valid2", 32'(bus.out_valid), 32'h4);
        check("bp_ch2_second", data_of(2), 32'hB2);
        @(negedge clk);
        check("bp_drained", 32'(bus.out_valid), 32'h0);

        // Full channel 1 with a pop in the same cycle.
        bus.out_ready = 4'b1101;
        @(negedge clk);
        drive(1'b1, 1, 32'h11);
        @(negedge clk);
        drive(1'b1, 1, 32'h22);
        @(negedge clk);
        drive(1'b1, 1, 32'h33);
        bus.out_ready = 4'hF;
        #1;
        check("fp_ready_full", 32'(bus.in_ready), 32'h0);
        check("fp_head11", data_of(1), 32'h11);
        @(negedge clk);
        check("fp_head22", data_of(1), 32'h22);
        #1 check("fp_ready_next", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        drive(1'b0, 0, 32'h0);
        check("fp_valid", 32'(bus.out_valid), 32'h2);
        check("fp_head33", data_of(1), 32'h33);
        @(negedge clk);
        check("fp_drained", 32'(bus.out_valid), 32'h0);

        // Pointer wrap on channel 3 with a toggling consumer.
        tx = 0;
        rx = 0;
        for (int c = 0; c < 80 && rx < 10; c++) begin
            @(negedge clk);
            bus.out_ready = (c % 2 == 0) ? 4'b1000 : 4'b0000;
            if (tx < 10) drive(1'b1, 3, 32'(tx));
            else drive(1'b0, 0, 32'h0);
            #1;
            if (bus.out_valid[3] && bus.out_ready[3]) begin
                check("wrap_data", data_of(3), 32'(rx));
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
        end
        check("wrap_count", 32'(rx), 32'd10);
        @(negedge clk);
        drive(1'b0, 0, 32'h0);
        bus.out_ready = 4'h0;
        @(negedge clk);
        check("wrap_drained", 32'(bus.out_valid), 32'h0);

        // Asynchronous reset with words buffered.
        @(negedge clk);
        drive(1'b1, 0, 32'hD0);
        @(negedge clk);
        drive(1'b1, 1, 32'hD1);
        @(negedge clk);
        drive(1'b0, 0, 32'h0);
        check("rst_pre_valid", 32'(bus.out_valid), 32'h3);
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_post_valid", 32'(bus.out_valid), 32'h0);
`ifdef DEMUX_STATS_EN
        for (int k = 0; k < 4; k++) check("rst_stat", stat_of(k), 32'h0);

        // Saturation: 20 deliveries on channel 0 with a 4-bit counter.
        bus.out_ready = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) check("stat_mid", stat_of(0), 32'd9);
            drive(1'b1, 0, 32'(100 + i));
        end
        @(negedge clk);
        drive(1'b0, 0, 32'h0);
        repeat (2) @(negedge clk);
        check("stat_sat", stat_of(0), 32'd15);
        for (int k = 1; k < 4; k++) check("stat_other", stat_of(k), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
